// File: rtl/polymult_host.sv
// polymult_host: loads operands A/B into the coefficient RAM, kicks the
// multiplier, then streams the product C back out as valid/ready beats.
// Ports: cmd_* request, in_* operand stream, mem_* RAM port,
// start/write_enable/mult_done multiplier handshake, out_* product stream.
module polymult_host #(
  parameter int COEF_W  = 13,
  parameter int ADDR_W  = 11,
  parameter int BASE_A  = 0,
  parameter int BASE_B  = 768,
  parameter int BASE_C  = 0,
  parameter int TIMEOUT = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [10:0]       cmd_dega,
  input  logic [10:0]       cmd_degb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [COEF_W-1:0] mem_wdata,
  input  logic [COEF_W-1:0] mem_rdata,
  output logic              start,
  output logic              write_enable,
  input  logic              mult_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] A0 = ADDR_W'(BASE_A);
  localparam logic [ADDR_W-1:0] B0 = ADDR_W'(BASE_B);
  localparam logic [ADDR_W-1:0] C0 = ADDR_W'(BASE_C);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_ARM,
    S_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [10:0]       k_q, k_d;
  logic [10:0]       dega_q, dega_d;
  logic [10:0]       degb_q, degb_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic [COEF_W-1:0] odata_q, odata_d;
  logic              olast_q, olast_d;

  logic        xfer;
  logic [11:0] deg_sum;

  // product has dega+degb+1 terms; sum kept in 12 bits
  assign deg_sum = {1'b0, dega_q} + {1'b0, degb_q};

  assign cmd_ready    = (state_q == S_IDLE);
  assign in_ready     = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign xfer         = in_valid && in_ready;
  assign mem_we       = xfer;
  assign mem_wdata    = xfer ? in_data : '0;
  assign start        = (state_q == S_START);
  assign write_enable = (state_q == S_ARM) || (state_q == S_WAIT);
  assign out_valid    = (state_q == S_OUT);
  assign out_data     = odata_q;
  assign out_last     = out_valid && olast_q;
  assign busy         = (state_q != S_IDLE);
  assign err_timeout  = err_q;

  always_comb begin
    mem_addr = '0;
    unique case (1'b1)
      state_q == S_LOAD_A:   mem_addr = A0 + ADDR_W'(k_q);
      state_q == S_LOAD_B:   mem_addr = B0 + ADDR_W'(k_q);
      state_q == S_RD_ISSUE: mem_addr = C0 + ADDR_W'(k_q);
      default:               mem_addr = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dega_d  = dega_q;
    degb_d  = degb_q;
    wd_d    = wd_q;
    err_d   = err_q;
    odata_d = odata_q;
    olast_d = olast_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dega_d  = cmd_dega;
          degb_d  = cmd_degb;
          err_d   = 1'b0;
          k_d     = '0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (xfer) begin
          if (k_q == dega_q) begin
            k_d     = '0;
            state_d = S_LOAD_B;
          end else begin
            k_d = k_q + 11'd1;
          end
        end
      end
      S_LOAD_B: begin
        if (xfer) begin
          if (k_q == degb_q) begin
            k_d     = '0;
            state_d = S_START;
          end else begin
            k_d = k_q + 11'd1;
          end
        end
      end
      S_START: state_d = S_ARM;
      S_ARM: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // completion beats the watchdog on the same cycle
        if (mult_done) begin
          k_d     = '0;
          state_d = S_RD_ISSUE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        odata_d = mem_rdata;
        olast_d = ({1'b0, k_q} == deg_sum);
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (olast_q) begin
            state_d = S_IDLE;
          end else begin
            k_d     = k_q + 11'd1;
            state_d = S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      dega_q  <= '0;
      degb_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      odata_q <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dega_q  <= dega_d;
      degb_q  <= degb_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      odata_q <= odata_d;
      olast_q <= olast_d;
    end
  end

endmodule
